ws2812_frame_parser: RTL and testbench

WS2812_FRAME_PARSER -- requirements
Module: ws2812_frame_parser

---
 rtl/ws2812_pkg.sv | 13 +
 rtl/ws2812_dim.sv | 10 +
 rtl/ws2812_frame_parser.sv | 68 ++++++
 tb/tb_ws2812_frame_parser.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: command codes, parser state encoding and command decode helpers
package ws2812_pkg;
   localparam logic [7:0] CMD_NOP    = 8'h00;
   localparam logic [7:0] CMD_BRIGHT = 8'h01;
   localparam logic [7:0] CMD_COUNT  = 8'h02;
   typedef enum logic [2:0] {IDLE, GET_BRIGHT, GET_COUNT, PIXEL, DONE} state_t;
   function automatic state_t cmd_next(input logic [7:0] cmd);
      return cmd == CMD_BRIGHT ? GET_BRIGHT : cmd == CMD_COUNT ? GET_COUNT : IDLE;
   endfunction
   function automatic logic cmd_known(input logic [7:0] cmd);
      return cmd == CMD_NOP || cmd == CMD_BRIGHT || cmd == CMD_COUNT;
   endfunction
endpackage

// File: rtl/ws2812_dim.sv
// ws2812_dim: combinational brightness scaling, (data*(bright+1))>>8
module ws2812_dim (
   input  logic [7:0] data,
   input  logic [7:0] bright,
   output logic [7:0] scaled
);
   logic [16:0] prod;
   assign prod   = {9'd0, data} * ({9'd0, bright} + 17'd1);
   assign scaled = 8'(prod >> 8);
endmodule

// File: rtl/ws2812_frame_parser.sv
// ws2812_frame_parser: parses UART command/payload bytes into brightness-scaled LED colour bytes
module ws2812_frame_parser
   import ws2812_pkg::*;
#(
   parameter int         MAX_LEDS   = 256,
   parameter logic [7:0] BRIGHT_RST = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_cmd,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_done,
   output logic       frame_abort,
   output logic       err
);
   localparam int RW = $clog2(3 * MAX_LEDS + 1);
   state_t        state, state_n;
   logic [RW-1:0] remaining, count_load;
   logic [7:0]    bright, scaled;
   logic          accept, take_cmd, take_data;
   assign accept     = in_valid && in_ready;
   assign take_cmd   = accept && in_cmd;
   assign take_data  = accept && !in_cmd;
   assign count_load = in_data == 8'd0 ? RW'(3 * MAX_LEDS) : RW'(in_data) * RW'(3);
   ws2812_dim u_dim (.data(in_data), .bright(bright), .scaled(scaled));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:       if (take_cmd) state_n = cmd_next(in_data);
         GET_BRIGHT: if (accept) state_n = in_cmd ? cmd_next(in_data) : IDLE;
         GET_COUNT:  if (accept) state_n = in_cmd ? cmd_next(in_data) : PIXEL;
         PIXEL:      if (accept) state_n = in_cmd ? cmd_next(in_data) : remaining == RW'(1) ? DONE : PIXEL;
         DONE:       if (!out_valid) state_n = IDLE;
         default:    state_n = IDLE;
      endcase
   end
   always_comb in_ready = state == PIXEL ? (!out_valid || out_ready) : state != DONE;
   // A command in PIXEL aborts the frame but the byte already held still drains normally
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         remaining   <= '0;
         bright      <= BRIGHT_RST;
         out_valid   <= 1'b0;
         out_data    <= 8'd0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         err         <= 1'b0;
      end else begin
         frame_done  <= state == DONE && !out_valid;
         frame_abort <= state == PIXEL && take_cmd;
         err         <= err || (take_cmd && !cmd_known(in_data)) || (take_data && state == IDLE);
         if (state == GET_BRIGHT && take_data) bright <= in_data;
         if (state == GET_COUNT && take_data) remaining <= count_load;
         else if (state == PIXEL && accept) remaining <= in_cmd ? '0 : remaining - RW'(1);
         if (state == PIXEL && take_data) begin
            out_valid <= 1'b1;
            out_data  <= scaled;
         end else if (out_ready) out_valid <= 1'b0;
      end
endmodule

// File: tb/tb_ws2812_frame_parser.sv
// tb_ws2812_frame_parser: transaction-level reference model with per-cycle compare plus directed literal checks
module tb_ws2812_frame_parser;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_cmd = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       frame_done, frame_abort, err;
   ws2812_frame_parser dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_cmd(in_cmd), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .frame_done(frame_done), .frame_abort(frame_abort), .err(err)
   );
   always #5 clk = ~clk;
   int         checks = 0, errors = 0;
   int         n_done = 0, n_abort = 0;
   // model: 0 cmd-wait, 1 expect brightness, 2 expect count, 3 pixel bytes, 4 waiting for drain
   int         mode = 0, rem = 0;
   logic [7:0] mbright = 8'hFF;
   logic [7:0] q[$];
   logic [7:0] got[$];
   bit         done_exp = 0, abort_exp = 0, err_exp = 0, acc_m;
   bit         rnd_ready = 0, ready_hold = 1;
   logic [7:0] e35[3] = '{8'h10, 8'h80, 8'hFF};
   logic [7:0] e36[3] = '{8'h7F, 8'h40, 8'h01};
   logic [7:0] e39[3] = '{8'h5A, 8'h00, 8'hFF};
   logic [7:0] b37[6] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask
   function automatic logic [7:0] dim(input logic [7:0] d, input logic [7:0] b);
      int p;
      p = int'(d) * (int'(b) + 1);
      return 8'(p / 256);
   endfunction
   function automatic bit exp_ready();
      return mode <= 2 ? 1'b1 : mode == 3 ? (q.size() == 0 || out_ready) : 1'b0;
   endfunction
   task automatic model_reset();
      mode = 0; rem = 0; mbright = 8'hFF; q.delete();
      done_exp = 0; abort_exp = 0; err_exp = 0;
   endtask
   task automatic model_byte(input bit c, input logic [7:0] d);
      if (c) begin
         if (mode == 3) begin abort_exp = 1; rem = 0; end
         mode = d == 8'h01 ? 1 : d == 8'h02 ? 2 : 0;
         if (d > 8'h02) err_exp = 1;
      end else if (mode == 0) err_exp = 1;
      else if (mode == 1) begin mbright = d; mode = 0; end
      else if (mode == 2) begin rem = d == 0 ? 768 : 3 * int'(d); mode = 3; end
      else begin
         q.push_back(dim(d, mbright));
         rem--;
         if (rem == 0) mode = 4;
      end
   endtask
   always @(posedge clk) begin
      #2;
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
   end
   always @(negedge clk) begin
      if (!rst_n) model_reset();
      else begin
         chk("out_valid", out_valid, q.size() != 0);
         if (out_valid && q.size() != 0) chk("out_data", out_data, q[0]);
         chk("in_ready", in_ready, exp_ready());
         chk("frame_done", frame_done, done_exp);
         chk("frame_abort", frame_abort, abort_exp);
         chk("err", err, err_exp);
         if (frame_done) n_done++;
         if (frame_abort) n_abort++;
         acc_m = in_valid && exp_ready();
         done_exp = 0; abort_exp = 0;
         if (mode == 4 && q.size() == 0) begin done_exp = 1; mode = 0; end
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            if (q.size() != 0) void'(q.pop_front());
         end
         if (acc_m) model_byte(in_cmd, in_data);
      end
   end
   task automatic send(input bit c, input logic [7:0] d);
      bit acc = 0;
      int n = 0;
      in_valid = 1; in_cmd = c; in_data = d;
      while (!acc && n < 2000) begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1; n++;
      end
      in_valid = 0;
      if (!acc) begin errors++; $display("FAIL send_timeout byte=%0h accepted=0 required=1", d); end
   endtask
   task automatic wait_idle();
      int n = 0;
      while (!(mode == 0 && q.size() == 0 && !done_exp) && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 3000) begin errors++; $display("FAIL idle_timeout mode=%0d required=0", mode); end
      repeat (2) begin @(posedge clk); #1; end
   endtask
   task automatic pulse_reset();
      #1 rst_n = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_abort", frame_abort, 0);
      chk("rst_err", err, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("pin_dim_ff", dim(8'h80, 8'hFF), 8'h80);
      chk("pin_dim_7f", dim(8'hFF, 8'h7F), 8'h7F);
      chk("pin_dim_0", dim(8'hC3, 8'h00), 8'h00);
      // unity brightness passes bytes through, one frame_done
      got.delete(); n_done = 0;
      send(1, 8'h02); send(0, 8'h01);
      foreach (e35[i]) send(0, e35[i]);
      wait_idle();
      chk("req035_count", got.size(), 3);
      foreach (e35[i]) chk("req035_byte", got[i], e35[i]);
      chk("req035_done", n_done, 1);
      // half brightness
      got.delete();
      send(1, 8'h01); send(0, 8'h7F);
      send(1, 8'h02); send(0, 8'h01);
      send(0, 8'hFF); send(0, 8'h80); send(0, 8'h02);
      wait_idle();
      chk("req036_count", got.size(), 3);
      foreach (e36[i]) chk("req036_byte", got[i], e36[i]);
      // downstream stall mid-frame
      send(1, 8'h01); send(0, 8'hFF);
      got.delete(); n_done = 0;
      send(1, 8'h02); send(0, 8'h02);
      for (int i = 0; i < 4; i++) send(0, b37[i]);
      ready_hold = 0;
      #2;
      fork
         begin repeat (10) @(posedge clk); #1 ready_hold = 1; end
      join_none
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_data", out_data, b37[3]);
      @(posedge clk); #1;
      send(0, b37[4]); send(0, b37[5]);
      wait_idle();
      chk("req037_count", got.size(), 6);
      foreach (b37[i]) chk("req037_byte", got[i], b37[i]);
      chk("req037_done", n_done, 1);
      // abort after 4 of 6 bytes
      got.delete(); n_done = 0; n_abort = 0;
      send(1, 8'h02); send(0, 8'h02);
      for (int i = 0; i < 4; i++) send(0, b37[i]);
      send(1, 8'h00);
      wait_idle();
      chk("req038_count", got.size(), 4);
      chk("req038_abort", n_abort, 1);
      chk("req038_done", n_done, 0);
      // error sources and reset recovery
      got.delete();
      chk("req039_err_clean", err, 0);
      send(1, 8'h55); repeat (2) @(posedge clk); #1;
      chk("req039_err_cmd", err, 1);
      pulse_reset();
      send(0, 8'h33); repeat (2) @(posedge clk); #1;
      chk("req039_err_payload", err, 1);
      chk("req039_no_out", got.size(), 0);
      pulse_reset();
      send(1, 8'h02); send(0, 8'h01);
      foreach (e39[i]) send(0, e39[i]);
      wait_idle();
      foreach (e39[i]) chk("req039_bright_rst", got[i], e39[i]);
      // count 0 is MAX_LEDS
      got.delete(); n_done = 0;
      send(1, 8'h02); send(0, 8'h00);
      for (int i = 0; i < 768; i++) send(0, 8'($urandom));
      wait_idle();
      chk("req040_count", got.size(), 768);
      chk("req040_done", n_done, 1);
      // reset with a held byte
      send(1, 8'h02); send(0, 8'h05);
      ready_hold = 0;
      send(0, 8'hAB);
      chk("req040_held", out_data, 8'hAB);
      got.delete(); n_done = 0; n_abort = 0;
      pulse_reset();
      ready_hold = 1;
      send(0, 8'h11); send(0, 8'h22);
      repeat (3) @(posedge clk); #1;
      chk("req040_post_err", err, 1);
      chk("req040_post_out", got.size(), 0);
      chk("req040_post_pulses", n_done + n_abort, 0);
      // randomized traffic
      pulse_reset();
      rnd_ready = 1;
      for (int k = 0; k < 60; k++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op < 2) begin send(1, 8'h01); send(0, 8'($urandom)); end
         else if (op == 2) send(1, 8'h00);
         else if (op == 3) send(1, 8'($urandom_range(3, 255)));
         else begin
            int nl;
            nl = $urandom_range(1, 4);
            send(1, 8'h02); send(0, 8'(nl));
            for (int i = 0; i < 3 * nl; i++) begin
               if ($urandom_range(0, 19) == 0) begin send(1, 8'($urandom_range(0, 2))); break; end
               send(0, 8'($urandom));
            end
         end
      end
      send(1, 8'h00);
      rnd_ready = 0; ready_hold = 1;
      wait_idle();
      chk("final_drain", q.size(), 0);
      chk("final_out_valid", out_valid, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
